bus_matrix: RTL
===============

// Module: bus_matrix
// PURPOSE
//  Registered N-master / N-slave data bus replacing the combinational 1-master/2-slave decoder.
//  Arbitrates core, uart and future masters round-robin onto shared RAM, button and peripheral slaves.
//  Adds slave wait-states, decode-miss and timeout error reporting.
//  Sits between masters (riscv core, uart loader) and slaves (ram, button, ...) in the soc top.
// PARAMETERS
//  WIDTH    32  data/address width
//  NMASTER  2   number of masters (>=1)
//  NSLAVE   4   number of slaves (<=bus_pkg::MAXSLAVE)
//  TIMEOUT  15  max XFER cycles waiting s_ready before error (>=1)
// PORTS
//  clk      in   1               single system clock, rising edge
//  rst      in   1               synchronous reset, active-high
//  m_req    in   NMASTER         master request; held high until m_ack
//  m_write  in   NMASTER         1=write, 0=read, per master
//  m_addr   in   NMASTER*WIDTH   byte address, master i at [i*WIDTH +: WIDTH]
//  m_wdata  in   NMASTER*WIDTH   write data, same packing
//  m_ack    out  NMASTER         one-cycle completion pulse to granted master
//  m_err    out  1               valid with m_ack: decode miss or timeout
//  m_rdata  out  WIDTH           read data, valid with m_ack
//  s_sel    out  NSLAVE          one-hot slave select (all zero when idle)
//  s_write  out  1               write strobe, qualified by s_sel
//  s_addr   out  WIDTH           registered address (offset = addr & ~MASK)
//  s_wdata  out  WIDTH           registered write data
//  s_rdata  in   NSLAVE*WIDTH    slave read data, slave j at [j*WIDTH +: WIDTH]
//  s_ready  in   NSLAVE          slave completes access this cycle
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; last-grant pointer = NMASTER-1 (master 0 wins first).
//  FSM IDLE -> XFER -> RESP -> IDLE; one outstanding transaction.
//  IDLE: if |m_req, winner = first requesting master after last grant (wrapping).
//    Register addr/wdata/write, decode slave, update pointer.
//    If decode hit, go XFER; if miss, go RESP with err=1, rdata=32'hDEAD_BEEF.
//  Decode: slave j hits when (addr & SLAVE_MASK[j]) == SLAVE_BASE[j]; lowest j wins on overlap.
//  XFER: s_sel[j]=1, s_write/s_addr/s_wdata stable, wait counter increments.
//    s_ready[j]=1: capture s_rdata (reads), go RESP, err=0.
//    Counter reaches TIMEOUT without ready: go RESP, err=1, rdata=32'hDEAD_BEEF.
//    s_ready of unselected slaves is ignored.
//  RESP: m_ack[winner]=1 for exactly one cycle, m_rdata/m_err valid; s_sel=0; next IDLE.
//  Latency: request seen in IDLE at cycle n, zero-wait slave -> m_ack at n+2.
//    k wait states -> m_ack at n+2+k. Decode miss -> m_ack at n+1.
//  Throughput: one transaction per 3 cycles; same master re-requesting yields to others (fairness).
//  m_req dropped mid-transaction: transaction completes, ack still pulses (master ignores).
//  Write to read-only slave: slave's problem; bus only reports decode/timeout errors.
//  Simultaneous requests: exactly one ack per RESP; others retain m_req and are served in rotation.
//  rst mid-transaction: abort immediately, s_sel=0 next cycle, no ack issued.
// STRUCTURE
//  bus_pkg: MAXSLAVE, SLAVE_BASE[], SLAVE_MASK[] (ram 0x0000_0000/0xFFF8_0000,
//    button 0x8000_0000/0xFFFF_FFFC), state_t enum {IDLE,XFER,RESP}, ERR_RDATA.
//  Sub-module rr_arbiter #(N): req vector + pointer -> one-hot grant and index; purely combinational.
//  bus_matrix holds FSM, grant/pointer regs, address/data regs, timeout counter, decode.
// TESTING
//  1. Single read: m0 reads 0x10, slave0 ready immediately, rdata=0x1234 -> s_sel=0001 at n+1; m_ack[0], m_rdata=0x1234, m_err=0 at n+2.
//  2. Contention: m0 and m1 request together, repeatedly -> grants alternate m0,m1,m0,m1; no lost or double ack.
//  3. Wait states: slave1 holds s_ready low 3 cycles on write 0xA5 to 0x8000_0000 -> s_wdata stable 4 cycles; ack at n+5, err=0.
//  4. Decode miss: m1 reads 0x4000_0000 -> s_sel never asserted; m_ack[1] at n+1, m_err=1, m_rdata=0xDEAD_BEEF.
//  5. Timeout: selected slave never ready, TIMEOUT=15 -> s_sel drops after 15 XFER cycles; ack with m_err=1.
//  6. Reset mid-XFER: rst high one cycle -> s_sel=0, no m_ack; next request from m0 served first.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the registered bus matrix.
//  MAXSLAVE    size of the slave address-map tables
//  SLAVE_BASE  per-slave base address (compared after masking)
//  SLAVE_MASK  per-slave decode mask; offset = addr & ~mask
//  state_t     transaction FSM states
//  ERR_RDATA   read data returned on decode miss or timeout
package bus_pkg;

   localparam int MAXSLAVE = 8;

   localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

   // Slot 0 ram, 1 button, 2/3 peripherals. Unused slots have a zero mask and
   // a non-zero base, so they can never match.
   localparam logic [31:0] SLAVE_BASE [MAXSLAVE] = '{
      32'h0000_0000, 32'h8000_0000, 32'h9000_0000, 32'hA000_0000,
      32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF
   };

   localparam logic [31:0] SLAVE_MASK [MAXSLAVE] = '{
      32'hFFF8_0000, 32'hFFFF_FFFC, 32'hFFFF_0000, 32'hFFFF_0000,
      32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter, purely combinational.
//  req    in   N   request vector
//  ptr    in   IW  index of the last granted requester
//  grant  out  N   one-hot grant (zero when no request)
//  idx    out  IW  index of the granted requester
//  valid  out  1   at least one request present
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          valid
);

   int cand;

   // Search starts one past the last grant and wraps, so the previous winner
   // is considered last.
   always_comb begin
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      cand  = 0;
      for (int k = 1; k <= N; k++) begin
         cand = (int'(ptr) + k) % N;
         if (!valid && req[cand]) begin
            valid       = 1'b1;
            grant[cand] = 1'b1;
            idx         = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/bus_matrix.sv
// Registered N-master / N-slave data bus with round-robin arbitration,
// slave wait-states, decode-miss and timeout error reporting.
//  clk      in   1              system clock, rising edge
//  rst      in   1              synchronous reset, active-high
//  m_req    in   NMASTER        per-master request, held until m_ack
//  m_write  in   NMASTER        per-master 1=write 0=read
//  m_addr   in   NMASTER*WIDTH  per-master byte address
//  m_wdata  in   NMASTER*WIDTH  per-master write data
//  m_ack    out  NMASTER        one-cycle completion pulse
//  m_err    out  1              decode miss or timeout, valid with m_ack
//  m_rdata  out  WIDTH          read data, valid with m_ack
//  s_sel    out  NSLAVE         one-hot slave select during transfer
//  s_write  out  1              write strobe, qualified by s_sel
//  s_addr   out  WIDTH          slave-relative address offset
//  s_wdata  out  WIDTH          write data
//  s_rdata  in   NSLAVE*WIDTH   per-slave read data
//  s_ready  in   NSLAVE         slave completes access this cycle
module bus_matrix
   import bus_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int NMASTER = 2,
   parameter int NSLAVE  = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NMASTER-1:0]        m_req,
   input  logic [NMASTER-1:0]        m_write,
   input  logic [NMASTER*WIDTH-1:0]  m_addr,
   input  logic [NMASTER*WIDTH-1:0]  m_wdata,
   output logic [NMASTER-1:0]        m_ack,
   output logic                      m_err,
   output logic [WIDTH-1:0]          m_rdata,
   output logic [NSLAVE-1:0]         s_sel,
   output logic                      s_write,
   output logic [WIDTH-1:0]          s_addr,
   output logic [WIDTH-1:0]          s_wdata,
   input  logic [NSLAVE*WIDTH-1:0]   s_rdata,
   input  logic [NSLAVE-1:0]         s_ready
);

   localparam int MW = (NMASTER > 1) ? $clog2(NMASTER) : 1;
   localparam int SW = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t             state;
   logic [MW-1:0]      ptr;
   logic [MW-1:0]      gnt;
   logic [SW-1:0]      slave_r;
   logic               write_r;
   logic               err_r;
   logic [WIDTH-1:0]   addr_r;
   logic [WIDTH-1:0]   wdata_r;
   logic [WIDTH-1:0]   rdata_r;
   logic [CW-1:0]      cnt;

   logic [NMASTER-1:0] arb_grant;
   logic [MW-1:0]      arb_idx;
   logic               arb_valid;
   logic [WIDTH-1:0]   win_addr;
   logic [WIDTH-1:0]   win_wdata;
   logic               dec_hit;
   logic [SW-1:0]      dec_idx;

   // Address decode; scanning downward lets the lowest matching slave win.
   function automatic void decode(input  logic [WIDTH-1:0] a,
                                  output logic             hit,
                                  output logic [SW-1:0]    idx);
      hit = 1'b0;
      idx = '0;
      for (int j = NSLAVE - 1; j >= 0; j--) begin
         if ((a & WIDTH'(SLAVE_MASK[j])) == WIDTH'(SLAVE_BASE[j])) begin
            hit = 1'b1;
            idx = SW'(j);
         end
      end
   endfunction

   rr_arbiter #(.N(NMASTER), .IW(MW)) u_arb (
      .req   (m_req),
      .ptr   (ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   always_comb begin
      win_addr  = m_addr[int'(arb_idx)*WIDTH +: WIDTH];
      win_wdata = m_wdata[int'(arb_idx)*WIDTH +: WIDTH];
      decode(win_addr, dec_hit, dec_idx);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= MW'(NMASTER - 1);
         gnt     <= '0;
         slave_r <= '0;
         write_r <= 1'b0;
         err_r   <= 1'b0;
         addr_r  <= '0;
         wdata_r <= '0;
         rdata_r <= '0;
         cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_valid) begin
                  ptr     <= arb_idx;
                  gnt     <= arb_idx;
                  write_r <= m_write[arb_idx];
                  wdata_r <= win_wdata;
                  slave_r <= dec_idx;
                  cnt     <= '0;
                  if (dec_hit) begin
                     addr_r <= win_addr & ~WIDTH'(SLAVE_MASK[dec_idx]);
                     state  <= XFER;
                  end else begin
                     // Miss skips the slave phase and answers next cycle.
                     addr_r  <= win_addr;
                     err_r   <= 1'b1;
                     rdata_r <= WIDTH'(ERR_RDATA);
                     state   <= RESP;
                  end
               end
            end
            XFER: begin
               // Ready takes priority over timeout on the final wait cycle.
               if (s_ready[slave_r]) begin
                  err_r   <= 1'b0;
                  rdata_r <= write_r ? '0 : s_rdata[int'(slave_r)*WIDTH +: WIDTH];
                  state   <= RESP;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  err_r   <= 1'b1;
                  rdata_r <= WIDTH'(ERR_RDATA);
                  state   <= RESP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs are decoded from registered state, so they change only at edges.
   always_comb begin
      s_sel   = (state == XFER) ? (NSLAVE'(1) << slave_r) : '0;
      s_write = (state == XFER) && write_r;
      s_addr  = addr_r;
      s_wdata = wdata_r;
      m_ack   = (state == RESP) ? (NMASTER'(1) << gnt) : '0;
      m_err   = (state == RESP) && err_r;
      m_rdata = (state == RESP) ? rdata_r : '0;
   end

endmodule
